// File: rtl/rx_iq_pack_pkg.sv
// rx_iq_pack_pkg: shared channel count, IQ sample width and word-select encodings
package rx_iq_pack_pkg;
  localparam int V_RX_CHANS = 4;
  localparam int IQ_W = 24;
  typedef enum logic [1:0] {WSEL_IHI = 2'd0, WSEL_QHI = 2'd1, WSEL_LO = 2'd2} wsel_t;
endpackage

// File: rtl/rx_iq_pack_if.sv
// rx_iq_pack_if: downstream bus to the memory writer (master: rx_avail_A/rxn_din_A/ticks_A out, rd_getI/rd_getQ in)
interface rx_iq_pack_if #(parameter int N = rx_iq_pack_pkg::V_RX_CHANS) ();
  logic rd_getI;
  logic rd_getQ;
  logic rx_avail_A;
  logic [N*16-1:0] rxn_din_A;
  logic [47:0] ticks_A;
  modport master (input rd_getI, rd_getQ, output rx_avail_A, rxn_din_A, ticks_A);
  modport slave (output rd_getI, rd_getQ, input rx_avail_A, rxn_din_A, ticks_A);
endinterface

// File: rtl/rx_iq_pack_chan.sv
// rx_iq_chan: one channel's capture/hold registers, have bit, overrun flag and 3:1 word mux (clk, rst, i_en/i_strb/i_i/i_q in, i_swap/i_sel control, o_have/o_ovfl/o_word out)
module rx_iq_chan import rx_iq_pack_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_strb,
  input  logic            i_swap,
  input  logic [IQ_W-1:0] i_i,
  input  logic [IQ_W-1:0] i_q,
  input  wsel_t           i_sel,
  output logic            o_have,
  output logic            o_ovfl,
  output logic [15:0]     o_word
);
  logic [IQ_W-1:0] r_cap_i, r_cap_q, r_hold_i, r_hold_q;
  logic r_have;
  logic w_take;
  assign w_take = i_strb & i_en;
  always_ff @(posedge clk)
    if (rst) begin
      r_cap_i  <= '0;
      r_cap_q  <= '0;
      r_hold_i <= '0;
      r_hold_q <= '0;
      r_have   <= 1'b0;
    end else begin
      if (w_take) begin
        r_cap_i <= i_i;
        r_cap_q <= i_q;
      end
      if (i_swap) begin
        r_hold_i <= i_en ? r_cap_i : '0;
        r_hold_q <= i_en ? r_cap_q : '0;
      end
      r_have <= i_en & (w_take | (r_have & ~i_swap));
    end
  assign o_have = r_have;
  assign o_ovfl = w_take & r_have & ~i_swap;
  assign o_word = i_sel == WSEL_IHI ? r_hold_i[IQ_W-1 -: 16] :
                  i_sel == WSEL_QHI ? r_hold_q[IQ_W-1 -: 16] :
                  {r_hold_i[7:0], r_hold_q[7:0]};
endmodule

// File: rtl/rx_iq_pack.sv
// rx_iq_pack: gathers one IQ sample per enabled channel, timestamps and swaps complete sets into a hold bank (adc_clk, reset_A, rx_en/in_strb/in_i/in_q/ticks_in in, bus to memory writer, ovfl_cnt out)
module rx_iq_pack #(
  parameter int V_RX_CHANS = rx_iq_pack_pkg::V_RX_CHANS,
  parameter int MIN_GAP = 3*V_RX_CHANS+8
) (
  input  logic                     adc_clk,
  input  logic                     reset_A,
  input  logic [V_RX_CHANS-1:0]    rx_en,
  input  logic [V_RX_CHANS-1:0]    in_strb,
  input  logic [V_RX_CHANS*24-1:0] in_i,
  input  logic [V_RX_CHANS*24-1:0] in_q,
  input  logic [47:0]              ticks_in,
  rx_iq_pack_if.master             bus,
  output logic [15:0]              ovfl_cnt
);
  import rx_iq_pack_pkg::*;
  localparam int GW = $clog2(MIN_GAP+1);
  localparam int CW = $clog2(V_RX_CHANS+1);
  logic [V_RX_CHANS-1:0] w_have, w_ovfl;
  logic [V_RX_CHANS*16-1:0] w_din;
  logic [CW-1:0] w_novf;
  logic [16:0] w_osum;
  logic w_complete, w_swap, w_first;
  logic [GW-1:0] r_gap;
  logic [47:0] r_ts_cap, r_ticks;
  wsel_t r_sel;
  logic r_avail;
  logic [15:0] r_ovfl;
  for (genvar g = 0; g < V_RX_CHANS; g++) begin : g_chan
    rx_iq_chan u_chan (
      .clk(adc_clk), .rst(reset_A), .i_en(rx_en[g]), .i_strb(in_strb[g]), .i_swap(w_swap),
      .i_i(in_i[24*g +: 24]), .i_q(in_q[24*g +: 24]), .i_sel(r_sel),
      .o_have(w_have[g]), .o_ovfl(w_ovfl[g]), .o_word(w_din[16*g +: 16])
    );
  end
  always_comb begin
    w_novf = '0;
    for (int k = 0; k < V_RX_CHANS; k++) w_novf = w_novf + CW'(w_ovfl[k]);
  end
  assign w_osum = {1'b0, r_ovfl} + 17'(w_novf);
  assign w_complete = (&(w_have | ~rx_en)) & (|(w_have & rx_en));
  assign w_swap = w_complete & (r_gap == '0);
  // a strobe landing on the swap edge opens the next set, so it stamps too
  assign w_first = (|(in_strb & rx_en)) & (~(|w_have) | w_swap);
  always_ff @(posedge adc_clk)
    if (reset_A) begin
      r_gap    <= '0;
      r_ts_cap <= '0;
      r_ticks  <= '0;
      r_sel    <= WSEL_IHI;
      r_avail  <= 1'b0;
      r_ovfl   <= '0;
    end else begin
      r_avail <= w_swap;
      r_gap   <= w_swap ? GW'(MIN_GAP-1) : r_gap != '0 ? r_gap - GW'(1) : '0;
      r_sel   <= bus.rd_getQ ? WSEL_LO : bus.rd_getI ? WSEL_QHI : WSEL_IHI;
      r_ovfl  <= w_osum[16] ? 16'hFFFF : w_osum[15:0];
      if (w_first) r_ts_cap <= ticks_in;
      if (w_swap) r_ticks <= r_ts_cap;
    end
  assign bus.rx_avail_A = r_avail;
  assign bus.rxn_din_A = w_din;
  assign bus.ticks_A = r_ticks;
  assign ovfl_cnt = r_ovfl;
endmodule

// File: tb/tb_rx_iq_pack.sv
// tb_rx_iq_pack: directed scoreboard bench for rx_iq_pack
module tb_rx_iq_pack;
  localparam int N = 4;
  localparam int GAP = 3*N+8;
  typedef struct packed {
    logic [47:0]     ts;
    logic [N*24-1:0] i;
    logic [N*24-1:0] q;
  } set_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] rx_en, in_strb;
  logic [N*24-1:0] in_i, in_q;
  logic [47:0] tick_cnt = '0;
  logic [15:0] ovfl_cnt;
  logic [23:0] di[N], dq[N];
  set_t sb[$];
  set_t a_set;
  int vec = 0, miss = 0, pulses = 0, p0;
  logic [47:0] t0, t2, at, pa, pb;
  logic [15:0] ov0;
  always #5 clk = ~clk;
  always @(posedge clk) tick_cnt <= tick_cnt + 48'd1;
  rx_iq_pack_if #(.N(N)) bus ();
  rx_iq_pack #(.V_RX_CHANS(N)) dut (
    .adc_clk(clk), .reset_A(rst), .rx_en(rx_en), .in_strb(in_strb), .in_i(in_i), .in_q(in_q),
    .ticks_in(tick_cnt), .bus(bus), .ovfl_cnt(ovfl_cnt)
  );
  always @(posedge clk) if (bus.rx_avail_A === 1'b1) pulses <= pulses + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic drv(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      in_i[24*k +: 24] = di[k];
      in_q[24*k +: 24] = dq[k];
    end
    in_strb = m;
    step();
    in_strb = '0;
  endtask
  function automatic set_t mk(input logic [47:0] ts);
    set_t s;
    s.ts = ts;
    for (int k = 0; k < N; k++) begin
      s.i[24*k +: 24] = rx_en[k] ? di[k] : 24'd0;
      s.q[24*k +: 24] = rx_en[k] ? dq[k] : 24'd0;
    end
    return s;
  endfunction
  function automatic logic [63:0] wd(input set_t e, input int w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      r[16*k +: 16] = w == 0 ? e.i[24*k+8 +: 16] : w == 1 ? e.q[24*k+8 +: 16] : {e.i[24*k +: 8], e.q[24*k +: 8]};
    return r;
  endfunction
  task automatic wait_set(input string tag, input int budget, output logic [47:0] when);
    int k;
    set_t e;
    k = 0;
    while (bus.rx_avail_A !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    when = tick_cnt;
    chk({tag, " pulse"}, {63'd0, bus.rx_avail_A}, 64'd1);
    if (bus.rx_avail_A === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " ticks_A"}, 64'(bus.ticks_A), 64'(e.ts));
      bus.rd_getI = 1'b1;
      chk({tag, " I-high"}, 64'(bus.rxn_din_A), wd(e, 0));
      step();
      bus.rd_getI = 1'b0;
      bus.rd_getQ = 1'b1;
      chk({tag, " one-cycle"}, {63'd0, bus.rx_avail_A}, 64'd0);
      chk({tag, " Q-high"}, 64'(bus.rxn_din_A), wd(e, 1));
      step();
      bus.rd_getQ = 1'b0;
      chk({tag, " low"}, 64'(bus.rxn_din_A), wd(e, 2));
      step();
    end
  endtask
  initial begin
    rx_en = '1;
    in_strb = '0;
    in_i = '0;
    in_q = '0;
    bus.rd_getI = 1'b0;
    bus.rd_getQ = 1'b0;
    for (int k = 0; k < N; k++) begin
      di[k] = '0;
      dq[k] = '0;
    end
    idle(3);
    rst = 1'b0;
    chk("rst avail", {63'd0, bus.rx_avail_A}, 64'd0);
    chk("rst din", 64'(bus.rxn_din_A), 64'd0);
    chk("rst ticks", 64'(bus.ticks_A), 64'd0);
    chk("rst ovfl", 64'(ovfl_cnt), 64'd0);
    idle(2);
    for (int k = 0; k < N; k++) begin
      di[k] = 24'h123456 + 24'(k);
      dq[k] = 24'hABCDEF - 24'(k);
    end
    t0 = tick_cnt;
    drv(4'b0001);
    drv(4'b0010);
    drv(4'b0100);
    sb.push_back(mk(t0));
    drv(4'b1000);
    wait_set("t1", 10, at);
    chk("t1 pulse cycle", 64'(at), 64'(t0 + 48'd5));
    idle(25);
    rx_en = 4'b0101;
    di[0] = 24'h0F1E2D; dq[0] = 24'h3C4B5A;
    di[1] = 24'h999999; dq[1] = 24'h888888;
    di[2] = 24'h778899; dq[2] = 24'hAABBCC;
    di[3] = 24'h555555; dq[3] = 24'h666666;
    p0 = pulses;
    t0 = tick_cnt;
    drv(4'b0001);
    drv(4'b0010);
    idle(6);
    chk("t2 no pulse", 64'(pulses - p0), 64'd0);
    chk("t2 disabled no ovfl", 64'(ovfl_cnt), 64'd0);
    sb.push_back(mk(t0));
    drv(4'b0100);
    wait_set("t2", 10, at);
    idle(25);
    rx_en = '1;
    di[1] = 24'h111111; dq[1] = 24'h222222;
    t0 = tick_cnt;
    drv(4'b0010);
    di[1] = 24'h333333; dq[1] = 24'h444444;
    drv(4'b0010);
    chk("t3 ovfl", 64'(ovfl_cnt), 64'd1);
    di[0] = 24'hC0FFEE; dq[0] = 24'h00BEEF;
    di[2] = 24'h7FFFFF; dq[2] = 24'h800000;
    di[3] = 24'hFEDCBA; dq[3] = 24'h012345;
    sb.push_back(mk(t0));
    drv(4'b1101);
    wait_set("t3", 10, at);
    idle(25);
    for (int k = 0; k < N; k++) begin
      di[k] = 24'hA00000 + 24'(k * 24'h010101);
      dq[k] = 24'h0B0000 + 24'(k * 24'h020202);
    end
    a_set = mk(tick_cnt);
    sb.push_back(a_set);
    p0 = pulses;
    drv('1);
    wait_set("t4a", 10, pa);
    for (int k = 0; k < N; k++) begin
      di[k] = 24'h5A5A00 + 24'(k);
      dq[k] = 24'hA5A500 + 24'(k);
    end
    sb.push_back(mk(tick_cnt));
    drv('1);
    idle(5);
    chk("t4 deferred", {63'd0, bus.rx_avail_A}, 64'd0);
    chk("t4 hold kept", 64'(bus.rxn_din_A), wd(a_set, 0));
    wait_set("t4b", 40, pb);
    chk("t4 gap", 64'(pb - pa), 64'(GAP));
    idle(2);
    chk("t4 pulses", 64'(pulses - p0), 64'd2);
    idle(25);
    ov0 = ovfl_cnt;
    for (int k = 0; k < N; k++) begin
      di[k] = 24'h010203 * 24'(k + 1);
      dq[k] = 24'h302010 * 24'(k + 1);
    end
    t0 = tick_cnt;
    drv(4'b0111);
    sb.push_back(mk(t0));
    drv(4'b1000);
    di[0] = 24'hDEAD12; dq[0] = 24'hBEEF34;
    t2 = tick_cnt;
    drv(4'b0001);
    wait_set("t5a", 4, at);
    chk("t5 ovfl same", 64'(ovfl_cnt), 64'(ov0));
    for (int k = 1; k < N; k++) begin
      di[k] = 24'h600000 + 24'(k);
      dq[k] = 24'h700000 + 24'(k);
    end
    sb.push_back(mk(t2));
    drv(4'b1110);
    wait_set("t5b", 40, at);
    idle(25);
    for (int k = 0; k < N; k++) begin
      di[k] = 24'h246800 + 24'(k);
      dq[k] = 24'h135700 + 24'(k);
    end
    drv(4'b0111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0 = pulses;
    idle(5);
    chk("t6 no pulse", 64'(pulses - p0), 64'd0);
    chk("t6 din", 64'(bus.rxn_din_A), 64'd0);
    chk("t6 ticks", 64'(bus.ticks_A), 64'd0);
    chk("t6 ovfl", 64'(ovfl_cnt), 64'd0);
    t0 = tick_cnt;
    sb.push_back(mk(t0));
    drv('1);
    wait_set("t6", 10, at);
    chk("t6 pulse cycle", 64'(at), 64'(t0 + 48'd2));
    chk("sb empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/rx_iq_pack.md
Name: rx_iq_pack

Overview:
- Upstream neighbour of the rx audio shared-sample-memory writer.
- Collects one 24-bit I/Q sample per enabled receiver channel from the per-channel decimation outputs and timestamps each complete set.
- When every enabled channel has contributed, swaps the set into a holding bank and pulses rx_avail_A.
- The memory writer then pulls three 16-bit words per channel using its rd_getI / rd_getQ strobes.

Parameters:
- V_RX_CHANS, 4, number of receiver channels; normally overridden from kiwi.gen.vh.
- MIN_GAP, 3*V_RX_CHANS+8, minimum adc_clk cycles between swaps; covers one full downstream transfer.

Ports:
- adc_clk  in  1  sole clock.
- reset_A  in  1  synchronous, active-high reset.
- rx_en  in  V_RX_CHANS  per-channel enable mask.
- in_strb  in  V_RX_CHANS  per-channel sample-valid pulse.
- in_i  in  V_RX_CHANS*24  per-channel I, two's complement; channel n at [24n+23:24n].
- in_q  in  V_RX_CHANS*24  per-channel Q, same packing as in_i.
- ticks_in  in  48  free-running tick counter.
- rd_getI  in  1  downstream strobe: the I-high word is being written this cycle.
- rd_getQ  in  1  downstream strobe: the Q-high word is being written this cycle.
- rx_avail_A  out  1  one-cycle pulse: new set is present in the holding bank.
- rxn_din_A  out  V_RX_CHANS*16  per-channel current word; channel n at [16n+15:16n].
- ticks_A  out  48  timestamp of the held set.
- ovfl_cnt  out  16  saturating count of overrun events.

Behaviour:
- Reset (reset_A=1 at an edge):
  - Clears all capture/hold registers, have[], the word selector, the gap counter, ticks_A and ovfl_cnt.
  - rx_avail_A=0 and rxn_din_A=0 on the next cycle.
  - Reset mid-set or mid-transfer simply discards everything; no pulse is issued.
- Capture:
  - On in_strb[n] & rx_en[n], latch in_i/in_q into cap[n] and set have[n].
  - Strobes on disabled channels are ignored.
- Timestamp: when have==0 and any enabled strobe arrives, latch ticks_in into ts_cap (first sample of the set).
- Overrun: a strobe on channel n with have[n] already 1:
  - overwrites cap[n];
  - increments ovfl_cnt, saturating at 0xFFFF;
  - leaves ts_cap unchanged.
- Completion: complete = &(have | ~rx_en) & |(have & rx_en), evaluated on registered state.
  - rx_en=0 (all channels disabled) never completes.
  - Clearing rx_en[n] clears have[n] on the next edge.
- Swap fires when complete and gap_cnt==0:
  - hold[n] <= cap[n] for enabled channels; hold[n] <= 0 for disabled channels.
  - ticks_A <= ts_cap.
  - have <= 0.
  - gap_cnt <= MIN_GAP-1.
  - rx_avail_A asserts the cycle after the swap edge, for exactly 1 cycle.
- Gap counter: decrements to 0 each cycle. A swap with gap_cnt != 0 is deferred; captures continue and overrun rules apply meanwhile.
- Strobe coincident with a swap:
  - The swap uses pre-edge cap contents.
  - The new strobe loads cap and sets have for the next set.
  - This is not counted as an overrun.
  - If it is the first of the next set, ts_cap takes ticks_in.
- Word sequencing: registered selector sel <= rd_getQ ? 2 : rd_getI ? 1 : 0 (rd_getQ wins if both are high). The selector is shared by all channels.
  - sel==0 (the cycle rd_getI is high, selector still 0): rxn_din_A[n] = hold_i[n][23:8].
  - sel==1 (the cycle after rd_getI): rxn_din_A[n] = hold_q[n][23:8].
  - sel==2 (the cycle after rd_getQ): rxn_din_A[n] = {hold_i[n][7:0], hold_q[n][7:0]}.
  - Net effect: the words for cycles t, t+1, t+2 of a downstream I,Q,idle move are I-high, Q-high, low-bytes.
  - The output is a combinational mux from registered state; no added latency.
- The holding bank is never modified except at a swap.

Decomposition:
- Shared package / kiwi.gen.vh:
  - V_RX_CHANS;
  - IQ sample width 24;
  - word-select encodings WSEL_IHI=0, WSEL_QHI=1, WSEL_LO=2.
- One sub-module, rx_iq_chan: per-channel cap/hold registers, have bit and 3:1 word mux, instantiated V_RX_CHANS times.
- The top level holds the completion logic, timestamp, gap counter, overrun counter and selector.

Test Plan:
- All 4 enabled; strobe ch0..3 on cycles 10..13 with I=0x123456+n, Q=0xABCDEF-n, ticks_in=cycle -> rx_avail_A on cycle 15; ticks_A=10; ch2 words 0x1234, 0xABCD, 0x58ED under strobe pattern I,Q,idle.
- rx_en=4'b0101; strobe ch0, ch2 only -> swap occurs; rxn_din_A ch1/ch3 words all 0x0000; no pulse if only ch0 strobes.
- Strobe ch1 twice before the set completes -> ovfl_cnt=1; second value held; ts_cap = first strobe's ticks.
- Set completes, then a second set completes 5 cycles later -> second swap deferred until MIN_GAP (20) cycles after the first; hold unchanged in between; exactly 2 pulses.
- Last strobe of a set coincident with a ch0 strobe of the next set -> first set held intact, ovfl_cnt unchanged, have[0]=1 afterward.
- Assert reset_A with 3 of 4 channels captured -> no rx_avail_A; all outputs 0; a fresh full set afterward swaps normally.
